// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package rst_seq_pkg;

  // FSM states; the encoding is visible on state_o for debug.
  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_INIT_WAIT = 3'd1,
    ST_GAP       = 3'd2,
    ST_RUN       = 3'd3,
    ST_SW_RST    = 3'd4
  } state_e;

  // Reset cause codes reported on rst_cause.
  localparam logic [1:0] CAUSE_POR = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  // Largest of four timing parameters; sizes the shared counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rst_seq.sv
// Staged reset sequencer: releases the memory domain, waits for its init
// (bounded by a timeout), then releases the core after a fixed gap.
// A soft reset request in RUN re-cycles only the core.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int HOLD_CYC     = 16,
  parameter int STAGE_GAP    = 4,
  parameter int INIT_TIMEOUT = 1024,
  parameter int SWRST_CYC    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_rst_req,
  input  logic       init_done,
  output logic       rst_n_mem,
  output logic       rst_n_core,
  output logic       init_timeout,
  output logic [1:0] rst_cause,
  output logic [2:0] state_o
);

  localparam int CW = $clog2(max4(HOLD_CYC, STAGE_GAP, INIT_TIMEOUT, SWRST_CYC)) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(INIT_TIMEOUT - 1);
  localparam logic [CW-1:0] SW_LAST   = CW'(SWRST_CYC - 1);

  state_e        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          mem_reg, mem_next;
  logic          core_reg, core_next;
  logic          to_reg, to_next;
  logic [1:0]    cause_reg, cause_next;

  // Next-state, counter and output-register decode.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    mem_next   = mem_reg;
    core_next  = core_reg;
    to_next    = to_reg;
    cause_next = cause_reg;
    case (state_reg)
      ST_HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = ST_INIT_WAIT;
          cnt_next   = '0;
          mem_next   = 1'b1;
        end
      end
      ST_INIT_WAIT: begin
        // init_done wins over a timeout landing on the same edge
        if (init_done) begin
          state_next = ST_GAP;
          cnt_next   = '0;
        end else if (cnt_reg == TO_LAST) begin
          state_next = ST_GAP;
          cnt_next   = '0;
          to_next    = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
          core_next  = 1'b1;
        end
      end
      ST_RUN: begin
        // counter is idle here; keep it parked at zero
        cnt_next = '0;
        if (sw_rst_req) begin
          state_next = ST_SW_RST;
          core_next  = 1'b0;
          cause_next = CAUSE_SW;
        end
      end
      ST_SW_RST: begin
        if (cnt_reg == SW_LAST) begin
          state_next = ST_GAP;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_HOLD;
        cnt_next   = '0;
        mem_next   = 1'b0;
        core_next  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers; rst_n low overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_HOLD;
      cnt_reg   <= '0;
      mem_reg   <= 1'b0;
      core_reg  <= 1'b0;
      to_reg    <= 1'b0;
      cause_reg <= CAUSE_POR;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mem_reg   <= mem_next;
      core_reg  <= core_next;
      to_reg    <= to_next;
      cause_reg <= cause_next;
    end
  end

  assign rst_n_mem    = mem_reg;
  assign rst_n_core   = core_reg;
  assign init_timeout = to_reg;
  assign rst_cause    = cause_reg;
  assign state_o      = state_reg;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: two instances (default timeout, and INIT_TIMEOUT=8 with
// init_done tied low) checked every cycle against an event-time model,
// plus literal edge-number checks in the directed sequences.
module tb_rst_seq;

  localparam int HOLD = 16;
  localparam int GAPC = 4;
  localparam int SWC  = 8;
  localparam int TO0  = 1024;
  localparam int TO1  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sw_rst_req = 1'b0;
  logic [1:0]       idone = 2'b00;
  logic [1:0]       mem_w, core_w, to_w;
  logic [1:0][1:0]  cause_w;
  logic [1:0][2:0]  st_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rst_seq #(.INIT_TIMEOUT(TO0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .init_done(idone[0]),
    .rst_n_mem(mem_w[0]), .rst_n_core(core_w[0]), .init_timeout(to_w[0]),
    .rst_cause(cause_w[0]), .state_o(st_w[0])
  );

  rst_seq #(.INIT_TIMEOUT(TO1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .init_done(idone[1]),
    .rst_n_mem(mem_w[1]), .rst_n_core(core_w[1]), .init_timeout(to_w[1]),
    .rst_cause(cause_w[1]), .state_o(st_w[1])
  );

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model: edge counts and release deadlines ----------------
  int   to_p[2] = '{TO0, TO1};
  int   m_e[2];        // edges since rst_n release
  int   m_due[2];      // edge at which core is (re)released
  bit   m_mem[2], m_core[2], m_to[2], m_res[2];
  int   m_cause[2];
  bit   m_valid = 1'b0;

  function automatic int exp_state(input int i);
    if (!m_mem[i])  return 0;
    if (!m_res[i])  return 1;
    if (m_core[i])  return 3;
    if (m_e[i] < m_due[i] - GAPC) return 4;
    return 2;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_e[i] = 0; m_due[i] = -1; m_mem[i] = 0; m_core[i] = 0;
        m_to[i] = 0; m_res[i] = 0; m_cause[i] = 1;
      end else begin
        m_e[i]++;
        if (!m_mem[i]) begin
          if (m_e[i] == HOLD) m_mem[i] = 1;
        end else if (!m_res[i]) begin
          if (idone[i]) begin
            m_res[i] = 1; m_due[i] = m_e[i] + GAPC;
          end else if (m_e[i] == HOLD + to_p[i]) begin
            m_res[i] = 1; m_to[i] = 1; m_due[i] = m_e[i] + GAPC;
          end
        end else if (m_core[i]) begin
          if (sw_rst_req) begin
            m_core[i] = 0; m_cause[i] = 2; m_due[i] = m_e[i] + SWC + GAPC;
          end
        end else if (m_e[i] == m_due[i]) begin
          m_core[i] = 1;
        end
      end
    end
    if (!rst_n) m_valid = 1'b1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("mem%0d", i),   int'(mem_w[i]),   int'(m_mem[i]));
        chk($sformatf("core%0d", i),  int'(core_w[i]),  int'(m_core[i]));
        chk($sformatf("to%0d", i),    int'(to_w[i]),    int'(m_to[i]));
        chk($sformatf("cause%0d", i), int'(cause_w[i]), m_cause[i]);
        chk($sformatf("state%0d", i), int'(st_w[i]),    exp_state(i));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic edge_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_mem%0d", tag, i),   int'(mem_w[i]),   0);
      chk($sformatf("%s_core%0d", tag, i),  int'(core_w[i]),  0);
      chk($sformatf("%s_to%0d", tag, i),    int'(to_w[i]),    0);
      chk($sformatf("%s_cause%0d", tag, i), int'(cause_w[i]), 1);
      chk($sformatf("%s_state%0d", tag, i), int'(st_w[i]),    0);
    end
  endtask

  // Release rst_n (edge 1 = next posedge) and run a power-on sequence.
  task automatic por_seq(input int init_from, input int core_edge,
                         input int sw_a, input int sw_b);
    int last;
    last = (core_edge > 28 ? core_edge : 28) + 2;
    rst_n = 1'b1;
    for (int e = 1; e <= last; e++) begin
      idone[0]   = (e >= init_from);
      sw_rst_req = (e == sw_a) || (e == sw_b);
      @(negedge clk);
      if (e == HOLD - 1)    chk("por_mem_early", int'(mem_w[0]), 0);
      if (e == HOLD)        chk("por_mem_rise",  int'(mem_w[0]), 1);
      if (e == core_edge-1) chk("por_core_early", int'(core_w[0]), 0);
      if (e == core_edge) begin
        chk("por_core_rise", int'(core_w[0]), 1);
        chk("por_cause",     int'(cause_w[0]), 1);
        chk("por_to0",       int'(to_w[0]), 0);
      end
      if (e == 23) chk("to1_early",  int'(to_w[1]), 0);
      if (e == 24) chk("to1_rise",   int'(to_w[1]), 1);
      if (e == 27) chk("core1_early", int'(core_w[1]), 0);
      if (e == 28) chk("core1_rise", int'(core_w[1]), 1);
    end
    sw_rst_req = 1'b0;
  endtask

  initial begin
    int low;
    int highs;

    edge_n(3);
    chk_reset_vals("init");

    // power-on with sw_rst_req pulsed during HOLD and INIT_WAIT (ignored)
    por_seq(1, 21, 3, 17);

    // single soft-reset pulse in RUN
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    chk("sw_core_drop", int'(core_w[0]), 0);
    chk("sw_cause",     int'(cause_w[0]), 2);
    low = 1;
    while (core_w[0] == 1'b0 && low < 40) begin
      @(negedge clk);
      if (core_w[0] == 1'b0) low++;
    end
    chk("sw_low_len",  low, 12);
    chk("sw_mem_kept", int'(mem_w[0]), 1);
    chk("sw_to1_kept", int'(to_w[1]), 1);

    // held request: single-cycle core windows every 13 cycles
    edge_n(2);
    sw_rst_req = 1'b1;
    highs = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      highs += int'(core_w[0]);
    end
    sw_rst_req = 1'b0;
    chk("sw_hold_highs", highs, 3);
    edge_n(20);

    // rst_n asserted during SW_RST
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    edge_n(2);
    chk("in_swrst", int'(st_w[0]), 4);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("swrst_abort");
    por_seq(1, 21, 0, 0);

    // init_done arrives 100 cycles after memory release
    rst_n = 1'b0;
    edge_n(2);
    por_seq(117, 121, 0, 0);

    // rst_n asserted during GAP
    rst_n = 1'b0;
    edge_n(2);
    rst_n = 1'b1;
    idone[0] = 1'b1;
    edge_n(18);
    chk("in_gap", int'(st_w[0]), 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("gap_abort");
    por_seq(1, 21, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Staged reset sequencer downstream of the reset synchronizer; its rst_n input is the synchronizer's synchronously released reset.
- Releases the memory/peripheral domain first, waits for memory init (with timeout), then releases the core after a fixed gap.
- Supports a software/debug-initiated core-only reset that leaves the memory domain running.

Parameters:
HOLD_CYC, 16, cycles all domains stay in reset after rst_n is sampled high (>=1)
STAGE_GAP, 4, cycles between leaving init wait and releasing core (>=1)
INIT_TIMEOUT, 1024, max cycles waited for init_done before forcing progress (>=1)
SWRST_CYC, 8, cycles core is held in SW_RST on a soft reset (>=1)

Ports:
clk  in  1  system clock, single domain
rst_n  in  1  synchronous active-low reset; driven by the reset synchronizer output
sw_rst_req  in  1  soft core reset request; sampled only in RUN
init_done  in  1  memory/peripheral init complete; sampled only in INIT_WAIT
rst_n_mem  out  1  active-low reset to memory/peripheral domain, registered
rst_n_core  out  1  active-low reset to CPU core, registered
init_timeout  out  1  sticky: init_done never seen before timeout
rst_cause  out  2  2'b01 power-on, 2'b10 soft reset
state_o  out  3  current FSM state, debug only

Behaviour:
- All outputs registered; single clock; rst_n sampled only on posedge clk. rst_n low dominates every other input.
- On reset: state=HOLD, cnt=0, rst_n_mem=0, rst_n_core=0, init_timeout=0, rst_cause=2'b01.
- Counter: one shared counter of width $clog2(max param)+1, cleared on every state transition.
- Edge numbering: edge 1 is the first posedge with rst_n sampled 1.
- HOLD: cnt counts; at cnt==HOLD_CYC-1, set rst_n_mem=1 and go to INIT_WAIT. rst_n_mem is high after edge HOLD_CYC.
- INIT_WAIT:
  - init_done=1 -> GAP.
  - Else if cnt==INIT_TIMEOUT-1 -> set init_timeout=1, go to GAP.
  - init_done has priority over timeout on the same edge.
- GAP: at cnt==STAGE_GAP-1, set rst_n_core=1 and go to RUN.
- Defaults with init_done already high: rst_n_mem high after edge 16, rst_n_core high after edge 21 (HOLD_CYC+1+STAGE_GAP).
- RUN: sw_rst_req=1 -> SW_RST; rst_n_core=0 from that edge; rst_cause=2'b10.
- SW_RST: at cnt==SWRST_CYC-1 -> GAP. rst_n_core is then re-released via GAP timing, so it is low for SWRST_CYC+STAGE_GAP cycles.
- rst_n_mem and init_timeout are unaffected by soft reset. init_timeout clears only on rst_n.
- sw_rst_req outside RUN is ignored and not latched.
- sw_rst_req held high: re-triggers on the first RUN edge, giving exactly one cycle of rst_n_core=1 between soft resets.
- init_done outside INIT_WAIT is ignored.
- rst_n low mid-sequence (any state): next edge returns to the reset values above, including rst_cause=2'b01.
- state_o encoding: HOLD=0, INIT_WAIT=1, GAP=2, RUN=3, SW_RST=4; 5..7 unreachable, default to HOLD.

Decomposition:
- Shared package rst_seq_pkg:
  - State enum (3-bit) with the state_o encoding.
  - Cause constants CAUSE_POR=2'b01, CAUSE_SW=2'b10.
- No sub-module: the single counter and FSM are inline; the block is one always_ff FSM plus output registers.

Test Plan:
- Power-on, defaults, init_done tied 1, rst_n released -> rst_n_mem rises after edge 16, rst_n_core after edge 21; init_timeout=0; rst_cause=01.
- init_done asserted 100 cycles after rst_n_mem rises -> rst_n_core rises 105 edges after rst_n_mem; init_timeout=0.
- init_done tied 0, INIT_TIMEOUT=8 -> init_timeout=1 after edge 24; rst_n_core rises after edge 28; timeout remains 1 through RUN.
- In RUN, 1-cycle sw_rst_req pulse -> rst_n_core low for exactly 12 cycles; rst_n_mem stays 1; rst_cause=10. Repeat with sw_rst_req held 40 cycles -> rst_n_core high for single-cycle windows every 13 cycles.
- rst_n pulled low during GAP and again during SW_RST -> next edge: both resets 0, state_o=0, rst_cause=01, init_timeout=0; full sequence replays with original timing.
- sw_rst_req pulsed during HOLD/INIT_WAIT -> ignored; power-on timing is identical to the first scenario.
